// File: rtl/sequence_generator.sv
// Serial pattern source: emits a captured pattern MSB-first, one update strobe per bit.
// First update one cycle after start; start ignored while busy, abort cancels at next edge.
module sequence_generator #(
    parameter int PATTERN_WIDTH = 8,
    parameter int LEN_W         = 4,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PATTERN_WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0]         length,
    output logic                     update,
    output logic                     value,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = (PATTERN_WIDTH > 1) ? $clog2(PATTERN_WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PATTERN_WIDTH);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t                   state, state_d;
    logic [PATTERN_WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]            idx, idx_d;
    logic [GW-1:0]            gap_cnt, gap_d;
    logic                     update_d, value_d, busy_d, done_d;

    logic                     len_ok;
    logic [LEN_W-1:0]         len_m1;
    logic [IW-1:0]            idx_first;
    logic [IW-1:0]            idx_nxt;

    assign len_ok    = (length != '0) && (length <= LEN_MAX);
    assign len_m1    = length - LEN_W'(1);
    assign idx_first = len_m1[IW-1:0];
    assign idx_nxt   = idx - IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            update  <= 1'b0;
            value   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            pat_q   <= pat_d;
            idx     <= idx_d;
            gap_cnt <= gap_d;
            update  <= update_d;
            value   <= value_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        pat_d    = pat_q;
        idx_d    = idx;
        gap_d    = gap_cnt;
        update_d = 1'b0;
        value_d  = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                // abort in the same cycle as start suppresses the launch
                if (start && !abort && len_ok) begin
                    pat_d    = pattern;
                    idx_d    = idx_first;
                    update_d = 1'b1;
                    value_d  = pattern[idx_first];
                    busy_d   = 1'b1;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (GAP_CYCLES == 0) begin
                    idx_d    = idx_nxt;
                    update_d = 1'b1;
                    value_d  = pat_q[idx_nxt];
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (gap_cnt <= GW'(1)) begin
                    idx_d    = idx_nxt;
                    update_d = 1'b1;
                    value_d  = pat_q[idx_nxt];
                    gap_d    = '0;
                    state_d  = EMIT;
                end else begin
                    gap_d = gap_cnt - GW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench: two generators (no gap, gap of 2) share stimulus; outputs sampled 1 time unit after each edge.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] pattern;
    logic [3:0] length;
    logic       upd0, val0, busy0, done0;
    logic       upd2, val2, busy2, done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sequence_generator #(.PATTERN_WIDTH(8), .LEN_W(4), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .length(length),
        .update(upd0), .value(val0), .busy(busy0), .done(done0)
    );

    sequence_generator #(.PATTERN_WIDTH(8), .LEN_W(4), .GAP_CYCLES(2)) dut_g2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .length(length),
        .update(upd2), .value(val2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {update, value, busy, done} of the no-gap instance
    task automatic chk0(input string tag, input logic [3:0] exp);
        chk(tag, {upd0, val0, busy0, done0}, exp);
    endtask

    task automatic run_bits0(input string tag, input logic [7:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            chk0(tag, {1'b1, bits[len-1-i], 1'b1, 1'b0});
            tick();
        end
    endtask

    initial begin
        logic [7:0] bits;
        int         k;
        logic       exp_u;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; length = '0;
        tick(); tick();
        chk0("reset_g0", 4'b0000);
        chk("reset_g2", {upd2, val2, busy2, done2}, 4'b0000);
        reset = 1'b0;
        tick();

        // 4-bit 1011, back-to-back
        pattern = 8'b0000_1011; length = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits0("t1_bit", 8'b0000_1011, 4);
        chk0("t1_done", 4'b0001);
        tick();
        chk0("t1_done_clr", 4'b0000);
        tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

        // gap instance: 8 bits spaced 3 cycles apart
        bits = 8'b1010_0101;
        pattern = bits; length = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            exp_u = ((c - 1) % 3 == 0);
            k = (c - 1) / 3;
            chk("t2_upd", {31'b0, upd2}, {31'b0, exp_u});
            chk("t2_val", {31'b0, val2}, {31'b0, exp_u & bits[7-k]});
            chk("t2_busy", {31'b0, busy2}, 32'd1);
            chk("t2_done", {31'b0, done2}, 32'd0);
            tick();
        end
        chk("t2_end", {upd2, val2, busy2, done2}, 4'b0001);
        tick();
        chk("t2_end_clr", {upd2, val2, busy2, done2}, 4'b0000);

        // illegal lengths
        pattern = 8'hFF; length = 4'd0; start = 1'b1;
        tick();
        chk0("t3_len0", 4'b0000);
        chk("t3_len0_g2", {upd2, val2, busy2, done2}, 4'b0000);
        length = 4'd9;
        tick();
        chk0("t3_len9", 4'b0000);
        start = 1'b0;
        tick();
        chk0("t3_after", 4'b0000);

        // abort and start together in idle
        length = 4'd4; start = 1'b1; abort = 1'b1;
        tick();
        chk0("t3_abort_start", 4'b0000);
        start = 1'b0; abort = 1'b0;
        tick();

        // start re-pulsed during bit 2 is ignored
        bits = 8'b0011_0100;
        pattern = bits; length = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        chk0("t4_bit1", {1'b1, bits[5], 2'b10});
        tick();
        chk0("t4_bit2", {1'b1, bits[4], 2'b10});
        start = 1'b1; pattern = 8'hFF; length = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 2; i < 6; i++) begin
            chk0("t4_bit", {1'b1, bits[5-i], 2'b10});
            tick();
        end
        chk0("t4_done", 4'b0001);
        tick();
        chk0("t4_single_done", 4'b0000);
        tick(); tick(); tick();

        // abort in bit 3, restart one cycle later
        pattern = 8'hFF; length = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk0("t5_bit3", 4'b1110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk0("t5_aborted", 4'b0000);
        bits = 8'h96;
        pattern = bits; start = 1'b1;
        tick();
        start = 1'b0;
        run_bits0("t5_bit", bits, 8);
        chk0("t5_done", 4'b0001);
        tick(); tick(); tick(); tick();

        // start held across done, then reset mid-emission
        pattern = 8'b0000_0101; length = 4'd3; start = 1'b1;
        tick();
        run_bits0("t6_bit", 8'b0000_0101, 3);
        chk0("t6_done", 4'b0001);
        tick();
        chk0("t6_restart", 4'b1110);
        start = 1'b0;
        tick();
        chk0("t6_bit2", 4'b1010);
        reset = 1'b1;
        tick();
        chk0("t6_reset", 4'b0000);
        reset = 1'b0;
        tick();
        chk0("t6_post_reset", 4'b0000);
        tick();
        chk0("t6_post_reset2", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
